// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD real-time clock (HH:MM:SS) driven by a one-second
// clock-enable, with N_ALARMS independently programmable alarm channels.
// Define SNOOZE_EN to build the SNOOZE input handling and the SNOOZED channel state.
module multi_alarm_clock #(
  parameter int unsigned CLK_HZ     = 10,
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [AW-1:0]       AL_SEL,
  input  logic [N_ALARMS-1:0] AL_ON,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  output logic                Alarm,
  output logic [N_ALARMS-1:0] Al_active,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0,
  output logic                tick_1s
);

  localparam int unsigned PW = $clog2(CLK_HZ);

`ifdef SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RING, SNOOZED} ch_state_t;
`else
  typedef enum logic {IDLE, RING} ch_state_t;
`endif

  logic [PW-1:0] cnt;
  logic          time_in_ok;
  logic          ld_time_ok;
  logic          ld_alarm_ok;
  logic          time_updated;
  logic          time_changed;
  logic          at_minute;
  logic [10:0]   now_min;
  logic [10:0]   in_min;
  logic [10:0]   alarm_min [N_ALARMS];
  ch_state_t     state     [N_ALARMS];
  ch_state_t     state_nxt [N_ALARMS];

  assign tick_1s    = (cnt == PW'(CLK_HZ - 1));
  assign time_in_ok = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                      && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
  assign ld_time_ok  = LD_time & time_in_ok;
  assign ld_alarm_ok = LD_alarm & time_in_ok & (32'(AL_SEL) < N_ALARMS);

  // Minute-of-day views of the running time and the load inputs, used for all comparisons.
  assign now_min   = 11'(H_out1) * 11'd600 + 11'(H_out0) * 11'd60 + 11'(M_out1) * 11'd10 + 11'(M_out0);
  assign in_min    = 11'(H_in1) * 11'd600 + 11'(H_in0) * 11'd60 + 11'(M_in1) * 11'd10 + 11'(M_in0);
  assign at_minute = (S_out1 == 4'd0) && (S_out0 == 4'd0);

  // Prescaler, BCD time counter and the two-stage time_changed pipeline.
  // time_changed trails the time update by one extra cycle so channels react
  // exactly two edges after the edge that changed the time.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      H_out1       <= '0;
      H_out0       <= '0;
      M_out1       <= '0;
      M_out0       <= '0;
      S_out1       <= '0;
      S_out0       <= '0;
      time_updated <= 1'b0;
      time_changed <= 1'b0;
    end else begin
      time_updated <= ld_time_ok | tick_1s;
      time_changed <= time_updated;
      if (ld_time_ok) begin
        cnt    <= '0;
        H_out1 <= H_in1;
        H_out0 <= H_in0;
        M_out1 <= M_in1;
        M_out0 <= M_in0;
        S_out1 <= '0;
        S_out0 <= '0;
      end else begin
        cnt <= tick_1s ? '0 : cnt + PW'(1);
        if (tick_1s) begin
          if (S_out0 != 4'd9) begin
            S_out0 <= S_out0 + 4'd1;
          end else begin
            S_out0 <= '0;
            if (S_out1 != 4'd5) begin
              S_out1 <= S_out1 + 4'd1;
            end else begin
              S_out1 <= '0;
              if (M_out0 != 4'd9) begin
                M_out0 <= M_out0 + 4'd1;
              end else begin
                M_out0 <= '0;
                if (M_out1 != 4'd5) begin
                  M_out1 <= M_out1 + 4'd1;
                end else begin
                  M_out1 <= '0;
                  if (H_out1 == 2'd2 && H_out0 == 4'd3) begin
                    H_out1 <= '0;
                    H_out0 <= '0;
                  end else if (H_out0 == 4'd9) begin
                    H_out0 <= '0;
                    H_out1 <= H_out1 + 2'd1;
                  end else begin
                    H_out0 <= H_out0 + 4'd1;
                  end
                end
              end
            end
          end
        end
      end
    end
  end

  // Alarm time storage, one minute-of-day register per channel.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      if (reset) begin
        alarm_min[i] <= '0;
      end else if (ld_alarm_ok && 32'(AL_SEL) == i) begin
        alarm_min[i] <= in_min;
      end
    end
  end

`ifdef SNOOZE_EN
  logic [N_ALARMS-1:0] snz_load;
  logic [10:0]         snz_min [N_ALARMS];
  logic [11:0]         snz_sum;
  logic [10:0]         snz_next;

  assign snz_sum  = {1'b0, now_min} + 12'(SNOOZE_MIN);
  assign snz_next = (snz_sum >= 12'd1440) ? 11'(snz_sum - 12'd1440) : snz_sum[10:0];

  // Snooze targets, latched when a ringing channel is snoozed.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      if (reset) begin
        snz_min[i] <= '0;
      end else if (snz_load[i]) begin
        snz_min[i] <= snz_next;
      end
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = SNOOZE;
`endif

  // Channel state registers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      state[i] <= reset ? IDLE : state_nxt[i];
    end
  end

  // Channel next-state logic; disable and reprogramming dominate, STOP_al beats SNOOZE and match.
  always_comb begin
`ifdef SNOOZE_EN
    snz_load = '0;
`endif
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      state_nxt[i] = state[i];
      if (!AL_ON[i] || (ld_alarm_ok && 32'(AL_SEL) == i)) begin
        state_nxt[i] = IDLE;
      end else begin
        case (state[i])
          IDLE: begin
            if (time_changed && at_minute && now_min == alarm_min[i] && !STOP_al) state_nxt[i] = RING;
          end
          RING: begin
            if (STOP_al) begin
              state_nxt[i] = IDLE;
`ifdef SNOOZE_EN
            end else if (SNOOZE) begin
              state_nxt[i] = SNOOZED;
              snz_load[i]  = 1'b1;
`endif
            end
          end
`ifdef SNOOZE_EN
          SNOOZED: begin
            if (STOP_al) state_nxt[i] = IDLE;
            else if (time_changed && at_minute && now_min == snz_min[i]) state_nxt[i] = RING;
          end
`endif
          default: state_nxt[i] = IDLE;
        endcase
      end
    end
  end

  // Ring flags and the combined buzzer output.
  always_comb begin
    Al_active = '0;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      Al_active[i] = (state[i] == RING);
    end
    Alarm = |Al_active;
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
`timescale 1ns/1ps
module tb_multi_alarm_clock;
  localparam int unsigned CLK_HZ     = 4;
  localparam int unsigned N_ALARMS   = 5;
  localparam int unsigned SNOOZE_MIN = 5;
  localparam int unsigned AW         = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          H_in1;
  logic [3:0]          H_in0, M_in1, M_in0;
  logic                LD_time, LD_alarm;
  logic [AW-1:0]       AL_SEL;
  logic [N_ALARMS-1:0] AL_ON;
  logic                STOP_al, SNOOZE;
  logic                Alarm;
  logic [N_ALARMS-1:0] Al_active;
  logic [1:0]          H_out1;
  logic [3:0]          H_out0, M_out1, M_out0, S_out1, S_out0;
  logic                tick_1s;

  always #5 clk = ~clk;

  multi_alarm_clock #(.CLK_HZ(CLK_HZ), .N_ALARMS(N_ALARMS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_ON(AL_ON),
    .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(Alarm), .Al_active(Al_active),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0), .tick_1s(tick_1s)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h1, h0, m1, m0;
    int exp_h, exp_m;
  } ld_vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int now_secs();
    return (int'(H_out1) * 10 + int'(H_out0)) * 3600 + (int'(M_out1) * 10 + int'(M_out0)) * 60
           + int'(S_out1) * 10 + int'(S_out0);
  endfunction

  task automatic ld_time_raw(input int h1, input int h0, input int m1, input int m0);
    H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
    LD_time = 1'b1;
    step();
    LD_time = 1'b0;
  endtask

  task automatic ld_time_hm(input int h, input int m);
    ld_time_raw(h / 10, h % 10, m / 10, m % 10);
  endtask

  task automatic ld_alarm(input int sel, input int h, input int m);
    H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
    AL_SEL = AW'(sel);
    LD_alarm = 1'b1;
    step();
    LD_alarm = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP_al = 1'b1;
    step();
    STOP_al = 1'b0;
  endtask

  task automatic wait_ring(input int mask, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      if (int'(Al_active) == mask) ok = 1'b1;
    end
  endtask

  initial begin
    ld_vec_t vecs [9];
    bit ok;
    int ticks;
    int base, cyc;

    vecs[0] = '{2, 3, 5, 9,  23, 59};
    vecs[1] = '{2, 4, 0, 0,  11, 11};
    vecs[2] = '{1, 9, 5, 9,  19, 59};
    vecs[3] = '{2, 0, 6, 0,  11, 11};
    vecs[4] = '{1, 2, 3, 10, 11, 11};
    vecs[5] = '{3, 0, 0, 0,  11, 11};
    vecs[6] = '{0, 0, 0, 0,  0,  0};
    vecs[7] = '{0, 9, 4, 5,  9,  45};
    vecs[8] = '{2, 3, 0, 15, 11, 11};

    reset = 1'b1; H_in1 = '0; H_in0 = '0; M_in1 = '0; M_in0 = '0;
    LD_time = 1'b0; LD_alarm = 1'b0; AL_SEL = '0; AL_ON = '0; STOP_al = 1'b0; SNOOZE = 1'b0;
    step();
    step();
    check("reset_time", now_secs(), 0);
    check("reset_alarm", int'(Alarm), 0);
    check("reset_active", int'(Al_active), 0);
    check("reset_tick", int'(tick_1s), 0);
    reset = 1'b0;

    // Ten seconds of free running.
    ticks = 0;
    for (int n = 0; n < 10 * CLK_HZ; n++) begin
      step();
      if (tick_1s) ticks++;
    end
    check("tick_count", ticks, 10);
    check("ten_seconds", now_secs(), 10);

    // Midnight wrap and an out-of-range hour.
    ld_time_hm(23, 59);
    for (int n = 0; n < 60 * CLK_HZ; n++) step();
    check("midnight_wrap", now_secs(), 0);
    ld_time_raw(2, 4, 0, 0);
    check("hour24_ignored", now_secs(), 0);

    // Load validity table.
    for (int v = 0; v < 9; v++) begin
      ld_time_hm(11, 11);
      ld_time_raw(vecs[v].h1, vecs[v].h0, vecs[v].m1, vecs[v].m0);
      check($sformatf("load_vec%0d", v), now_secs(), vecs[v].exp_h * 3600 + vecs[v].exp_m * 60);
    end

    // Two channels on the same minute: exact two-edge latency, then STOP_al.
    AL_ON = 5'b00101;
    ld_alarm(0, 0, 1);
    ld_alarm(2, 0, 1);
    ld_time_hm(0, 0);
    ok = 1'b0;
    for (int n = 0; n < 70 * CLK_HZ && !ok; n++) begin
      step();
      if (now_secs() == 60) ok = 1'b1;
    end
    check("reach_0001", int'(ok), 1);
    check("latency_edge0", int'(Al_active), 0);
    step();
    check("latency_edge1", int'(Al_active), 0);
    step();
    check("latency_edge2", int'(Al_active), 5);
    check("alarm_or", int'(Alarm), 1);
    pulse_stop();
    check("stop_clears", int'(Al_active), 0);
    check("stop_alarm", int'(Alarm), 0);

    // STOP_al held across a matching update keeps channels idle.
    STOP_al = 1'b1;
    ld_time_hm(0, 1);
    step();
    step();
    STOP_al = 1'b0;
    step();
    check("stop_beats_match", int'(Al_active), 0);

    // Snooze on channel 1 at 12:00.
    AL_ON = 5'b00010;
    ld_alarm(1, 12, 0);
    ld_time_hm(11, 59);
    wait_ring(2, 65 * CLK_HZ, ok);
    check("ch1_ring", int'(ok), 1);
    check("ch1_ring_time", now_secs(), 12 * 3600);
`ifdef SNOOZE_EN
    SNOOZE = 1'b1;
    step();
    SNOOZE = 1'b0;
    check("snooze_silences", int'(Alarm), 0);
    wait_ring(2, 6 * 60 * CLK_HZ, ok);
    check("snooze_rering", int'(ok), 1);
    check("snooze_rering_time", now_secs(), 12 * 3600 + 5 * 60);
    STOP_al = 1'b1;
    SNOOZE = 1'b1;
    step();
    STOP_al = 1'b0;
    SNOOZE = 1'b0;
    check("stop_beats_snooze", int'(Al_active), 0);
    ld_time_hm(12, 9);
    wait_ring(2, 70 * CLK_HZ, ok);
    check("no_resnooze", int'(ok), 0);
`else
    SNOOZE = 1'b1;
    step();
    SNOOZE = 1'b0;
    check("snooze_ignored", int'(Alarm), 1);
    pulse_stop();
    check("stop_after_snooze", int'(Al_active), 0);
`endif

    // Dropping AL_ON silences a ringing channel.
    AL_ON = 5'b01000;
    ld_alarm(3, 6, 30);
    ld_time_hm(6, 29);
    wait_ring(8, 65 * CLK_HZ, ok);
    check("ch3_ring", int'(ok), 1);
    AL_ON = 5'b00000;
    step();
    check("al_on_drop", int'(Al_active), 0);

    // Out-of-range channel loads change nothing; a valid load idles its channel.
    AL_ON = 5'b11111;
    for (int c = 0; c < 5; c++) ld_alarm(c, 8, 0);
    ld_time_hm(7, 59);
    wait_ring(31, 65 * CLK_HZ, ok);
    check("all_ring", int'(ok), 1);
    for (int s = 5; s < 8; s++) begin
      ld_alarm(s, 8, 1);
      check($sformatf("bad_sel%0d", s), int'(Al_active), 31);
    end
    ld_alarm(2, 8, 1);
    check("load_idles_ch2", int'(Al_active), 27);
    pulse_stop();
    ld_time_hm(7, 59);
    wait_ring(27, 65 * CLK_HZ, ok);
    check("alarm_values_kept", int'(ok), 1);
    pulse_stop();

    // Channel 4 at 23:58, snooze across midnight, then reset while ringing.
    AL_ON = 5'b10000;
    ld_alarm(4, 23, 58);
    ld_time_hm(23, 57);
    wait_ring(16, 65 * CLK_HZ, ok);
    check("ch4_ring", int'(ok), 1);
`ifdef SNOOZE_EN
    SNOOZE = 1'b1;
    step();
    SNOOZE = 1'b0;
    wait_ring(16, 6 * 60 * CLK_HZ, ok);
    check("snooze_wrap", int'(ok), 1);
    check("snooze_wrap_time", now_secs(), 3 * 60);
`endif
    reset = 1'b1;
    step();
    check("reset_ring_active", int'(Al_active), 0);
    check("reset_ring_alarm", int'(Alarm), 0);
    check("reset_ring_time", now_secs(), 0);
    check("reset_ring_tick", int'(tick_1s), 0);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("no_fire_on_release", int'(Al_active), 0);
    end

    // Random loads (valid and invalid) and run lengths against an arithmetic time model.
    AL_ON = '0;
    ld_time_hm(5, 5);
    base = 5 * 3600 + 5 * 60;
    cyc = 0;
    for (int it = 0; it < 40; it++) begin
      int h1, h0, m1, m0, len;
      bit valid;
      h1 = int'($urandom_range(0, 3));
      h0 = int'($urandom_range(0, 15));
      m1 = int'($urandom_range(0, 7));
      m0 = int'($urandom_range(0, 15));
      valid = (h0 <= 9) && (h1 * 10 + h0 <= 23) && (m1 <= 5) && (m0 <= 9);
      ld_time_raw(h1, h0, m1, m0);
      if (valid) begin
        base = (h1 * 10 + h0) * 3600 + (m1 * 10 + m0) * 60;
        cyc = 0;
      end else begin
        cyc++;
      end
      check("rand_load", now_secs(), (base + cyc / CLK_HZ) % 86400);
      len = int'($urandom_range(0, 120));
      for (int n = 0; n < len; n++) begin
        step();
        cyc++;
        check("rand_tick", int'(tick_1s), int'((cyc % CLK_HZ) == CLK_HZ - 1));
      end
      check("rand_time", now_secs(), (base + cyc / CLK_HZ) % 86400);
    end

    // Random single-channel alarms.
    for (int it = 0; it < 4; it++) begin
      int ch, am, pm;
      ch = int'($urandom_range(0, N_ALARMS - 1));
      am = int'($urandom_range(0, 1439));
      pm = (am + 1439) % 1440;
      AL_ON = '0;
      AL_ON[ch] = 1'b1;
      ld_alarm(ch, am / 60, am % 60);
      ld_time_hm(pm / 60, pm % 60);
      wait_ring(1 << ch, 65 * CLK_HZ, ok);
      check("rand_ring", int'(ok), 1);
      check("rand_ring_time", now_secs(), am * 60);
      pulse_stop();
      check("rand_stop", int'(Al_active), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised successor to the single-alarm 24-hour clock: one real-time HH:MM:SS counter plus N independently programmable alarm channels, each with its own enable and ring state machine and an optional snooze. The block runs entirely on the system clock using a one-second clock-enable, with no derived clock. It sits between the board input switches/buttons and the display/buzzer drivers.

## Interface
- CLK_HZ, 10: `clk` cycles per real-time second; must be ≥ 2.
- N_ALARMS, 4: number of alarm channels, 1..16.
- SNOOZE_MIN, 5: snooze delay in minutes, 1..59.
- clk  in  1  system clock (CLK_HZ Hz).
- reset  in  1  synchronous, active-high reset.
- H_in1  in  2  hour tens digit to load, 0..2.
- H_in0  in  4  hour units digit to load, 0..9.
- M_in1  in  4  minute tens digit to load, 0..5.
- M_in0  in  4  minute units digit to load, 0..9.
- LD_time  in  1  load time from inputs; seconds cleared.
- LD_alarm  in  1  load alarm channel AL_SEL from inputs.
- AL_SEL  in  AW  alarm channel index for LD_alarm; AW = max(1, clog2(N_ALARMS)).
- AL_ON  in  N_ALARMS  per-channel enable.
- STOP_al  in  1  silence all ringing/snoozed channels.
- SNOOZE  in  1  snooze all ringing channels.
- Alarm  out  1  OR of all channels in RING.
- Al_active  out  N_ALARMS  per-channel RING flag.
- H_out1, H_out0, M_out1, M_out0, S_out1, S_out0  out  2/4/4/4/4/4  current time, BCD.
- tick_1s  out  1  one-cycle pulse per second.

## Operation
- Prescaler counts 0..CLK_HZ-1; tick_1s = (count == CLK_HZ-1). Time advances on each tick edge.
- Time is held directly as BCD digits. The units digit wraps 9→0 and carries; the tens digit wraps 5→0 for seconds and minutes. Hours wrap 23→00. 23:59:59 + tick → 00:00:00.
- LD_time: if the inputs are valid (hour ≤ 23, minute tens ≤ 5, units ≤ 9), load HH:MM, set SS=00 and prescaler=0. Invalid inputs are ignored. LD_time has priority over a tick in the same cycle.
- LD_alarm: if the inputs are valid and AL_SEL < N_ALARMS, store HH:MM into that channel and force the channel to IDLE. Otherwise the load is ignored. LD_time and LD_alarm may act in the same cycle.
- time_changed: a registered flag, set the cycle after any tick advance or accepted LD_time.
- Match for channel i: time_changed & AL_ON[i] & current time == alarm_i HH:MM:00.
- Per-channel FSM, states IDLE / RING / SNOOZED:
  - IDLE→RING on match.
  - RING→IDLE on STOP_al.
  - RING→SNOOZED on SNOOZE; this latches snooze target = current HH:MM + SNOOZE_MIN minutes, mod 24h, with seconds 00.
  - SNOOZED→RING when time_changed and time == snooze target.
  - SNOOZED→IDLE on STOP_al.
  - Any state→IDLE when AL_ON[i]=0.
  - STOP_al beats SNOOZE in the same cycle. STOP_al beats a match in the same cycle, so the channel stays IDLE.
- Channels are independent: several may ring at once, and STOP_al/SNOOZE act on all of them.

## Timing
- Reset values: time 00:00:00, prescaler 0, all alarms 00:00, all channels IDLE, snooze targets 00:00, Alarm=0, Al_active=0, tick_1s=0.
- Reset is not a load, so no alarm fires on reset release.
- Time outputs are registered and update on the clk edge where tick_1s=1 or LD_time is accepted.
- Alarm/Al_active rise exactly 2 clk edges after the time-update edge that produced the match (time_changed edge + FSM edge).
- STOP_al/SNOOZE take effect at the next edge; Alarm falls 1 cycle after the input is sampled.
- Reset mid-ring clears everything at the next edge.

## Configuration
- SNOOZE_EN defined: SNOOZE input and the SNOOZED state are implemented as above.
- SNOOZE_EN undefined: SNOOZE is ignored, no snooze target registers are built, and the FSM is IDLE/RING only.

## Test plan
- Reset, run 10·CLK_HZ cycles → S_out=10, one tick_1s every CLK_HZ cycles.
- LD_time 23:59, run 60 s → 00:00:00 and the hour wraps. LD_time 24:00 → ignored, time unchanged.
- Load ch0=00:01 and ch2=00:01, AL_ON=0101. LD_time 00:00, run 60 s → Al_active=0101 two cycles after S_out=00, Alarm=1. Pulse STOP_al → both clear the next cycle.
- ch1=12:00 ringing, pulse SNOOZE (SNOOZE_EN, SNOOZE_MIN=5) → Alarm=0. Re-rings at 12:05:00. STOP_al and SNOOZE asserted together → IDLE.
- ch3 ringing, drop AL_ON[3] → Al_active[3]=0 the next cycle. LD_alarm with AL_SEL ≥ N_ALARMS → no channel changes.
- Snooze target 23:58+5 → rings at 00:03:00. Reset asserted while ringing → all outputs return to reset values.
